// File: rtl/abs_dif_pkg.sv
// Shared types and helpers for the sum-of-absolute-differences engine.
package abs_dif_pkg;

  // Widest operand the magnitude helper handles.
  localparam int MAX_N = 64;

  // Width of a block sum: LEN values of up to 2^n-1 each.
  function automatic int sum_width(input int n, input int len);
    return n + $clog2(len);
  endfunction

  // Exact magnitude |a-b| of two n-bit operands.
  // Operands are extended to MAX_N+1 bits: sign-extended when signed_mode is set, zero-extended otherwise.
  // They are then subtracted as signed values. The magnitude always fits in n unsigned bits.
  function automatic logic [MAX_N-1:0] abs_diff(input logic [MAX_N-1:0] a,
                                                input logic [MAX_N-1:0] b,
                                                input int               n,
                                                input bit               signed_mode);
    logic [MAX_N:0] ae;
    logic [MAX_N:0] be;
    logic [MAX_N:0] d;
    for (int i = 0; i <= MAX_N; i++) begin
      if (i < n) begin
        ae[i] = a[i];
        be[i] = b[i];
      end else begin
        ae[i] = signed_mode & a[n-1];
        be[i] = signed_mode & b[n-1];
      end
    end
    d = ae - be;
    if (d[MAX_N]) d = -d;
    return d[MAX_N-1:0];
  endfunction

endpackage

// File: rtl/abs_dif_acc_if.sv
// Operand stream and block-sum stream of the SAD engine.
// Handshake: a beat moves on a rising clk edge where valid && ready are both high.
// The sender keeps valid and its data stable until that edge.
// ready may depend combinationally on the receiver's own state but never on valid.
interface abs_dif_acc_if
  import abs_dif_pkg::*;
#(
  parameter int N   = 8,
  parameter int LEN = 16
);
  localparam int S  = sum_width(N, LEN);
  localparam int CW = $clog2(LEN);

  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  a_in;
  logic [N-1:0]  b_in;
  logic          out_valid;
  logic          out_ready;
  logic [S-1:0]  sad_out;
  logic [N-1:0]  dif_out;
  logic [CW-1:0] cnt_out;

  modport master (
    output in_valid, a_in, b_in, out_ready,
    input  in_ready, out_valid, sad_out, dif_out, cnt_out
  );

  modport slave (
    input  in_valid, a_in, b_in, out_ready,
    output in_ready, out_valid, sad_out, dif_out, cnt_out
  );
endinterface

// File: rtl/abs_dif_core.sv
// Combinational N-bit magnitude unit, unsigned or two's complement.
module abs_dif_core
  import abs_dif_pkg::*;
#(
  parameter int N      = 8,
  parameter int SIGNED = 0
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] dif
);

  // |a-b| truncated back to N bits; the result is exact at that width.
  always_comb dif = N'(abs_diff(MAX_N'(a), MAX_N'(b), N, SIGNED != 0));

endmodule

// File: rtl/abs_dif_acc.sv
// Streaming SAD engine.
// Stage 1 registers |a-b|. Stage 2 accumulates LEN differences and loads the block sum into a held output register.
module abs_dif_acc
  import abs_dif_pkg::*;
#(
  parameter int N      = 8,
  parameter int LEN    = 16,
  parameter int SIGNED = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  abs_dif_acc_if.slave  bus
);
  localparam int S  = sum_width(N, LEN);
  localparam int CW = $clog2(LEN);

  logic          pipe_en;
  logic          xfer;
  logic          last;
  logic          load;
  logic [N-1:0]  dif_c;
  logic [N-1:0]  d_reg;
  logic          d_vld;
  logic [S-1:0]  acc;
  logic [S-1:0]  acc_next;
  logic [CW-1:0] cnt;
  logic          out_valid_q;
  logic [S-1:0]  sad_q;

  abs_dif_core #(.N(N), .SIGNED(SIGNED)) u_core (
    .a   (bus.a_in),
    .b   (bus.b_in),
    .dif (dif_c)
  );

  // The whole pipe freezes only while a finished sum waits for its consumer.
  always_comb begin
    pipe_en  = !(out_valid_q && !bus.out_ready);
    xfer     = bus.in_valid && pipe_en;
    last     = (cnt == CW'(LEN - 1));
    acc_next = acc + S'(d_reg);
    load     = pipe_en && d_vld && last && !clr;
  end

  assign bus.in_ready  = pipe_en;
  assign bus.out_valid = out_valid_q;
  assign bus.sad_out   = sad_q;
  assign bus.dif_out   = d_reg;
  assign bus.cnt_out   = cnt;

  // Difference stage and accumulator.
  // clr discards the partial block and any pair offered alongside it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_reg <= '0;
      d_vld <= 1'b0;
      acc   <= '0;
      cnt   <= '0;
    end else if (clr) begin
      d_vld <= 1'b0;
      acc   <= '0;
      cnt   <= '0;
    end else if (pipe_en) begin
      if (xfer) begin
        d_reg <= dif_c;
        d_vld <= 1'b1;
      end else begin
        d_vld <= 1'b0;
      end
      if (d_vld) begin
        if (last) begin
          acc <= '0;
          cnt <= '0;
        end else begin
          acc <= acc_next;
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

  // Held output register; a new sum may replace one being accepted in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      sad_q       <= '0;
    end else if (load) begin
      out_valid_q <= 1'b1;
      sad_q       <= acc_next;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_abs_dif_acc.sv
// Directed bench for abs_dif_acc with three configurations: unsigned LEN=4, signed LEN=2, unsigned LEN=3.
module tb_abs_dif_acc;
  import abs_dif_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clr4 = 1'b0;
  logic clr2 = 1'b0;
  logic clr3 = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  abs_dif_acc_if #(.N(8), .LEN(4)) if4 ();
  abs_dif_acc_if #(.N(8), .LEN(2)) if2 ();
  abs_dif_acc_if #(.N(8), .LEN(3)) if3 ();

  abs_dif_acc #(.N(8), .LEN(4), .SIGNED(0)) u4 (.clk(clk), .rst_n(rst_n), .clr(clr4), .bus(if4.slave));
  abs_dif_acc #(.N(8), .LEN(2), .SIGNED(1)) u2 (.clk(clk), .rst_n(rst_n), .clr(clr2), .bus(if2.slave));
  abs_dif_acc #(.N(8), .LEN(3), .SIGNED(0)) u3 (.clk(clk), .rst_n(rst_n), .clr(clr3), .bus(if3.slave));

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send4(input int a, input int b);
    if4.in_valid = 1'b1;
    if4.a_in = 8'(a);
    if4.b_in = 8'(b);
    tick();
    if4.in_valid = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    if4.in_valid = 0; if4.a_in = 0; if4.b_in = 0; if4.out_ready = 1;
    if2.in_valid = 0; if2.a_in = 0; if2.b_in = 0; if2.out_ready = 1;
    if3.in_valid = 0; if3.a_in = 0; if3.b_in = 0; if3.out_ready = 1;
    rst_n = 1'b0;
    #12;
    n_checks++; if (if4.in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready: got %0b expected 1", if4.in_ready); end
    n_checks++; if (if4.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %0b expected 0", if4.out_valid); end
    n_checks++; if (if4.sad_out !== 10'd0) begin n_fail++; $display("FAIL rst_sad: got %0d expected 0", if4.sad_out); end
    n_checks++; if (if4.dif_out !== 8'd0) begin n_fail++; $display("FAIL rst_dif: got %0d expected 0", if4.dif_out); end
    n_checks++; if (if4.cnt_out !== 2'd0) begin n_fail++; $display("FAIL rst_cnt: got %0d expected 0", if4.cnt_out); end
    rst_n = 1'b1;
    tick();
    n_checks++; if (if4.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_idle_ov: got %0b expected 0", if4.out_valid); end
  endtask

  task automatic test_unsigned();
    int pa[4] = '{10, 3, 255, 7};
    int pb[4] = '{3, 10, 0, 7};
    int de[4] = '{7, 7, 255, 0};
    if4.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send4(pa[i], pb[i]);
      n_checks++; if (if4.dif_out !== 8'(de[i])) begin n_fail++; $display("FAIL u_dif[%0d]: got %0d expected %0d", i, if4.dif_out, de[i]); end
      n_checks++; if (if4.out_valid !== 1'b0) begin n_fail++; $display("FAIL u_early_ov[%0d]: got %0b expected 0", i, if4.out_valid); end
    end
    n_checks++; if (if4.cnt_out !== 2'd3) begin n_fail++; $display("FAIL u_cnt: got %0d expected 3", if4.cnt_out); end
    tick();
    n_checks++; if (if4.out_valid !== 1'b1) begin n_fail++; $display("FAIL u_ov: got %0b expected 1", if4.out_valid); end
    n_checks++; if (if4.sad_out !== 10'd269) begin n_fail++; $display("FAIL u_sad: got %0d expected 269", if4.sad_out); end
    tick();
    n_checks++; if (if4.out_valid !== 1'b0) begin n_fail++; $display("FAIL u_pulse: got %0b expected 0", if4.out_valid); end
  endtask

  task automatic test_signed();
    int pa[2] = '{-128, -5};
    int pb[2] = '{127, 3};
    int de[2] = '{255, 8};
    if2.out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      if2.in_valid = 1'b1;
      if2.a_in = 8'(pa[i]);
      if2.b_in = 8'(pb[i]);
      tick();
      n_checks++; if (if2.dif_out !== 8'(de[i])) begin n_fail++; $display("FAIL s_dif[%0d]: got %0d expected %0d", i, if2.dif_out, de[i]); end
    end
    if2.in_valid = 1'b0;
    tick();
    n_checks++; if (if2.out_valid !== 1'b1) begin n_fail++; $display("FAIL s_ov: got %0b expected 1", if2.out_valid); end
    n_checks++; if (if2.sad_out !== 9'd263) begin n_fail++; $display("FAIL s_sad: got %0d expected 263", if2.sad_out); end
    tick();
    n_checks++; if (if2.out_valid !== 1'b0) begin n_fail++; $display("FAIL s_pulse: got %0b expected 0", if2.out_valid); end
  endtask

  task automatic test_backpressure();
    int pa[8] = '{5, 1, 10, 0, 20, 3, 100, 8};
    int pb[8] = '{1, 5, 0, 0, 10, 9, 50, 1};
    logic [9:0] exp_q[$];
    logic [9:0] exp_v;
    int idx = 0;
    int stall = 0;
    int got = 0;
    bit xf;
    exp_q.push_back(10'd18);
    exp_q.push_back(10'd73);
    for (int cyc = 0; cyc < 100 && got < 2; cyc++) begin
      if4.out_ready = (stall >= 5);
      if (idx < 8) begin
        if4.in_valid = 1'b1;
        if4.a_in = 8'(pa[idx]);
        if4.b_in = 8'(pb[idx]);
      end else begin
        if4.in_valid = 1'b0;
      end
      #1;
      xf = if4.in_valid && if4.in_ready;
      exp_v = (exp_q.size() > 0) ? exp_q[0] : 10'h3ff;
      if (if4.out_valid && !if4.out_ready) begin
        stall++;
        n_checks++; if (if4.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready[%0d]: got %0b expected 0", cyc, if4.in_ready); end
        n_checks++; if (if4.sad_out !== exp_v) begin n_fail++; $display("FAIL bp_held[%0d]: got %0d expected %0d", cyc, if4.sad_out, exp_v); end
      end else if (if4.out_valid) begin
        n_checks++; if (if4.sad_out !== exp_v) begin n_fail++; $display("FAIL bp_sum[%0d]: got %0d expected %0d", got, if4.sad_out, exp_v); end
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        got++;
      end
      @(posedge clk);
      #1;
      if (xf) idx++;
    end
    n_checks++; if (got != 2) begin n_fail++; $display("FAIL bp_count: got %0d expected 2", got); end
    n_checks++; if (idx != 8) begin n_fail++; $display("FAIL bp_consumed: got %0d expected 8", idx); end
    n_checks++; if (stall != 5) begin n_fail++; $display("FAIL bp_stall: got %0d expected 5", stall); end
    if4.in_valid = 1'b0;
    if4.out_ready = 1'b1;
    tick();
  endtask

  task automatic test_back_to_back();
    bit exp_ov;
    if3.out_ready = 1'b1;
    if3.in_valid = 1'b1;
    if3.a_in = 8'd9;
    if3.b_in = 8'd1;
    for (int t = 1; t <= 12; t++) begin
      if (t <= 9) begin
        n_checks++; if (if3.in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready[%0d]: got %0b expected 1", t, if3.in_ready); end
      end
      tick();
      if (t == 9) if3.in_valid = 1'b0;
      exp_ov = (t == 4 || t == 7 || t == 10);
      n_checks++; if (if3.out_valid !== exp_ov) begin n_fail++; $display("FAIL b2b_ov[%0d]: got %0b expected %0b", t, if3.out_valid, exp_ov); end
      if (exp_ov) begin
        n_checks++; if (if3.sad_out !== 10'd24) begin n_fail++; $display("FAIL b2b_sad[%0d]: got %0d expected 24", t, if3.sad_out); end
      end
    end
  endtask

  task automatic test_clr();
    if4.out_ready = 1'b1;
    send4(5, 0);
    send4(6, 0);
    clr4 = 1'b1;
    if4.in_valid = 1'b1;
    if4.a_in = 8'd50;
    if4.b_in = 8'd0;
    tick();
    clr4 = 1'b0;
    if4.in_valid = 1'b0;
    n_checks++; if (if4.cnt_out !== 2'd0) begin n_fail++; $display("FAIL clr_cnt: got %0d expected 0", if4.cnt_out); end
    for (int i = 0; i < 4; i++) send4(2, 0);
    tick();
    n_checks++; if (if4.out_valid !== 1'b1) begin n_fail++; $display("FAIL clr_ov: got %0b expected 1", if4.out_valid); end
    n_checks++; if (if4.sad_out !== 10'd8) begin n_fail++; $display("FAIL clr_sad: got %0d expected 8", if4.sad_out); end
    tick();
    n_checks++; if (if4.out_valid !== 1'b0) begin n_fail++; $display("FAIL clr_pulse: got %0b expected 0", if4.out_valid); end
    if4.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send4(3, 0);
    tick();
    n_checks++; if (if4.sad_out !== 10'd12) begin n_fail++; $display("FAIL clr_sad2: got %0d expected 12", if4.sad_out); end
    clr4 = 1'b1;
    tick();
    clr4 = 1'b0;
    n_checks++; if (if4.out_valid !== 1'b1) begin n_fail++; $display("FAIL clr_hold_ov: got %0b expected 1", if4.out_valid); end
    n_checks++; if (if4.sad_out !== 10'd12) begin n_fail++; $display("FAIL clr_hold_sad: got %0d expected 12", if4.sad_out); end
    if4.out_ready = 1'b1;
    tick();
    n_checks++; if (if4.out_valid !== 1'b0) begin n_fail++; $display("FAIL clr_release: got %0b expected 0", if4.out_valid); end
  endtask

  task automatic test_reset_mid();
    if4.out_ready = 1'b1;
    send4(100, 0);
    send4(100, 0);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (if4.dif_out !== 8'd0) begin n_fail++; $display("FAIL rmid_dif: got %0d expected 0", if4.dif_out); end
    n_checks++; if (if4.cnt_out !== 2'd0) begin n_fail++; $display("FAIL rmid_cnt: got %0d expected 0", if4.cnt_out); end
    n_checks++; if (if4.out_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_ov: got %0b expected 0", if4.out_valid); end
    n_checks++; if (if4.in_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_ready: got %0b expected 1", if4.in_ready); end
    #2;
    rst_n = 1'b1;
    tick();
    send4(1, 2);
    send4(4, 1);
    send4(0, 0);
    send4(6, 6);
    tick();
    n_checks++; if (if4.out_valid !== 1'b1) begin n_fail++; $display("FAIL rmid_post_ov: got %0b expected 1", if4.out_valid); end
    n_checks++; if (if4.sad_out !== 10'd4) begin n_fail++; $display("FAIL rmid_post_sad: got %0d expected 4", if4.sad_out); end
    tick();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_backpressure();
    test_back_to_back();
    test_clr();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/abs_dif_acc.md
# abs_dif_acc

Streaming sum-of-absolute-differences engine: accepts one pair of N-bit operands per cycle over a valid/ready handshake and computes |a−b| in either unsigned or two's-complement mode. It accumulates LEN consecutive differences into one block sum and presents that sum on a held valid/ready output port. It is the parametrised, pipelined successor of the 4-bit combinational absolute-difference unit and sits between a sample source and block-metric logic such as a motion-search or match-scoring controller.

## Interface
- N, default 8: operand width, N ≥ 2.
- LEN, default 16: samples per block, LEN ≥ 2. Any value is legal; a power of two is not required.
- SIGNED, default 0: 0 treats operands as unsigned, 1 treats them as two's complement.
- S, derived as N + $clog2(LEN): width of the sum. It is not overridable.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- clr  in  1  synchronous clear of the partial block.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  engine can accept a pair.
- a_in  in  N  operand A.
- b_in  in  N  operand B.
- out_valid  out  1  block sum valid.
- out_ready  in  1  consumer accepts the sum.
- sad_out  out  S  block sum.
- dif_out  out  N  last registered |a−b|, for debug.
- cnt_out  out  $clog2(LEN)  samples accumulated in the current block.

## Operation
- Stall: pipe_en = !(out_valid && !out_ready).
  - in_ready = pipe_en, a combinational output.
  - A transfer occurs when in_valid && in_ready.
- Stage 1 (difference): on a transfer, d_reg <= |a_in − b_in| and d_vld <= 1. If pipe_en is high and there is no transfer, d_vld <= 0. If pipe_en is low, stage 1 holds.
- Difference width: the magnitude is always exact in N unsigned bits.
  - SIGNED=1: maximum |−2^(N−1) − (2^(N−1)−1)| = 2^N−1.
  - Compute with an N+1-bit signed subtraction, then negate if negative.
- Stage 2 (accumulate): applies when pipe_en && d_vld.
  - If cnt < LEN−1: acc <= acc + d_reg and cnt <= cnt+1.
  - If cnt == LEN−1: sad_out <= acc + d_reg, out_valid <= 1, acc <= 0, cnt <= 0.
- Output: out_valid clears on out_valid && out_ready, unless a new sum loads in the same cycle. In that case out_valid stays 1 and the new sum replaces the old one.
- Stall behaviour: sad_out and out_valid hold while out_ready is low. Stage 1, stage 2 and in_ready are all frozen. No sample is lost or duplicated.
- clr: has priority over stage-1 and stage-2 updates.
  - Sets acc=0, cnt=0, d_vld=0.
  - Does not touch out_valid or sad_out.
  - A pair offered in the same cycle as clr is dropped, even if in_ready is high.
- No overflow is possible: LEN·(2^N−1) < 2^S.

## Timing
- Reset values: in_ready=1 (follows pipe_en), out_valid=0, sad_out=0, dif_out=0, cnt_out=0, acc=0, d_vld=0.
- Reset mid-block: the partial sum is discarded.
- Per-sample latency: a transfer at edge k puts the difference on dif_out after edge k.
- Block latency: if the LEN-th pair transfers at edge k, out_valid rises after edge k+1.
- Throughput: one pair per cycle, including back-to-back blocks, as long as out_ready is high whenever out_valid is high.
- Output backpressure: stalls the input after zero cycles of slack.

## Structure
- Shared package abs_dif_pkg holds:
  - the localparam helper for S;
  - a function abs_diff(a, b, signed_mode) returning N bits.
- Sub-module abs_dif_core: a combinational N-bit, SIGNED-aware magnitude unit, instantiated once in stage 1.
- The top level holds the stage registers, the counter, the accumulator and the output register.

## Test plan
- Unsigned, N=8, LEN=4, out_ready=1: pairs (10,3), (3,10), (255,0), (7,7) -> dif_out 7, 7, 255, 0. sad_out=269 with a single out_valid pulse, one cycle after the 4th transfer.
- SIGNED=1, N=8, LEN=2: pairs (−128,127), (−5,3) -> dif_out 255 then 8. sad_out=263.
- Backpressure: 2 blocks streamed with out_ready=0 for 5 cycles after the first sum.
  - in_ready must drop while the first sum is held.
  - First sum held stable on sad_out.
  - Second sum correct; no sample lost.
- Back-to-back blocks, LEN=3, all pairs (9,1), out_ready=1 -> sad_out=24 every 3 cycles, continuous throughput.
- clr after 2 of 4 samples, then 4 pairs (2,0) -> sad_out=8. clr asserted while out_valid is high leaves the held sum intact.
- rst_n pulsed low mid-block -> all outputs go to their reset values immediately. The next full block sums from zero.
